stage2_decode: RTL and testbench

//  Instruction-decode stage of the 5-stage MIPS pipeline; consumes fetch-stage PC+4 and instruction.

---
 rtl/stage2_decode.sv | 245 ++++++++++++++++++++++++
 tb/tb_stage2_decode.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/stage2_decode.sv
`default_nettype none
// ============================================================================
//  Module      : stage2_decode
//  Description : Instruction-decode stage of a 5-stage MIPS pipeline.
//                Holds the IF/ID register, a 32x32 register file with
//                writeback bypass, the main control decoder, the load-use
//                hazard detector and the ID/EX output register.
//  Revision    : 1.0 - initial release
// ============================================================================
module stage2_decode #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] if_pc4,
  input  logic [WIDTH-1:0] if_instruction,
  input  logic             flush,
  input  logic             wb_reg_write,
  input  logic [4:0]       wb_write_reg,
  input  logic [WIDTH-1:0] wb_write_data,
  output logic             pc_enable,
  output logic             id_valid,
  output logic [WIDTH-1:0] id_pc4,
  output logic [WIDTH-1:0] id_read_data1,
  output logic [WIDTH-1:0] id_read_data2,
  output logic [WIDTH-1:0] id_sign_imm,
  output logic [4:0]       id_rs,
  output logic [4:0]       id_rt,
  output logic [4:0]       id_rd,
  output logic             id_reg_dst,
  output logic             id_alu_src,
  output logic             id_mem_to_reg,
  output logic             id_reg_write,
  output logic             id_mem_read,
  output logic             id_mem_write,
  output logic             id_branch,
  output logic [1:0]       id_alu_op
);

  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_LW    = 6'h23;
  localparam logic [5:0] c_OP_SW    = 6'h2B;
  localparam logic [5:0] c_OP_BEQ   = 6'h04;
  localparam logic [5:0] c_OP_ADDI  = 6'h08;

  // IF/ID pipeline register
  logic [WIDTH-1:0] ifid_pc4_q;
  logic [WIDTH-1:0] ifid_instr_q;
  logic             ifid_valid_q;

  // ID/EX pipeline register
  logic             id_valid_q;
  logic [WIDTH-1:0] id_pc4_q;
  logic [WIDTH-1:0] id_rd1_q;
  logic [WIDTH-1:0] id_rd2_q;
  logic [WIDTH-1:0] id_imm_q;
  logic [4:0]       id_rs_q;
  logic [4:0]       id_rt_q;
  logic [4:0]       id_rd_q;
  logic             id_reg_dst_q;
  logic             id_alu_src_q;
  logic             id_mem_to_reg_q;
  logic             id_reg_write_q;
  logic             id_mem_read_q;
  logic             id_mem_write_q;
  logic             id_branch_q;
  logic [1:0]       id_alu_op_q;

  // Register file storage
  logic [WIDTH-1:0] regs_q [32];

  // Decoded fields and next-state values for ID/EX
  logic [5:0]       op;
  logic [4:0]       rs;
  logic [4:0]       rt;
  logic [4:0]       rd;
  logic [WIDTH-1:0] sign_imm_d;
  logic [WIDTH-1:0] rd1_d;
  logic [WIDTH-1:0] rd2_d;
  logic             reg_dst_d;
  logic             alu_src_d;
  logic             mem_to_reg_d;
  logic             reg_write_d;
  logic             mem_read_d;
  logic             mem_write_d;
  logic             branch_d;
  logic [1:0]       alu_op_d;
  logic             stall;

  assign op         = ifid_instr_q[31:26];
  assign rs         = ifid_instr_q[25:21];
  assign rt         = ifid_instr_q[20:16];
  assign rd         = ifid_instr_q[15:11];
  assign sign_imm_d = {{(WIDTH-16){ifid_instr_q[15]}}, ifid_instr_q[15:0]};

  // Load-use hazard: the load in EX targets a register the instruction in ID reads
  assign stall = id_mem_read_q & id_valid_q & ifid_valid_q & (id_rt_q != 5'd0) &
                 ((id_rt_q == rs) | (id_rt_q == rt));

  assign pc_enable = ~stall;

  // IF/ID register: flush squashes, stall holds, otherwise load from fetch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ifid_pc4_q   <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
    end else if (flush) begin
      ifid_pc4_q   <= '0;
      ifid_instr_q <= '0;
      ifid_valid_q <= 1'b0;
    end else if (!stall) begin
      ifid_pc4_q   <= if_pc4;
      ifid_instr_q <= if_instruction;
      ifid_valid_q <= 1'b1;
    end
  end

  // Main control decoder; an empty IF/ID slot decodes to all-zero controls
  always_comb begin
    reg_dst_d    = 1'b0;
    alu_src_d    = 1'b0;
    mem_to_reg_d = 1'b0;
    reg_write_d  = 1'b0;
    mem_read_d   = 1'b0;
    mem_write_d  = 1'b0;
    branch_d     = 1'b0;
    alu_op_d     = 2'b00;
    if (ifid_valid_q) begin
      case (op)
        c_OP_RTYPE: begin
          reg_dst_d   = 1'b1;
          reg_write_d = 1'b1;
          alu_op_d    = 2'b10;
        end
        c_OP_LW: begin
          alu_src_d    = 1'b1;
          mem_to_reg_d = 1'b1;
          reg_write_d  = 1'b1;
          mem_read_d   = 1'b1;
        end
        c_OP_SW: begin
          alu_src_d   = 1'b1;
          mem_write_d = 1'b1;
        end
        c_OP_BEQ: begin
          branch_d = 1'b1;
          alu_op_d = 2'b01;
        end
        c_OP_ADDI: begin
          alu_src_d   = 1'b1;
          reg_write_d = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Register file reads with same-cycle writeback bypass; $0 always reads zero
  always_comb begin
    rd1_d = regs_q[rs];
    rd2_d = regs_q[rt];
    if (rs == 5'd0) begin
      rd1_d = '0;
    end else if (wb_reg_write && (wb_write_reg == rs)) begin
      rd1_d = wb_write_data;
    end
    if (rt == 5'd0) begin
      rd2_d = '0;
    end else if (wb_reg_write && (wb_write_reg == rt)) begin
      rd2_d = wb_write_data;
    end
  end

  // Register file write port; $0 is never written
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= '0;
      end
    end else if (wb_reg_write && (wb_write_reg != 5'd0)) begin
      regs_q[wb_write_reg] <= wb_write_data;
    end
  end

  // ID/EX register: flush or stall inserts a bubble, otherwise capture decode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n || flush || stall) begin
      if (!rst_n || flush || stall) begin
        id_valid_q      <= 1'b0;
        id_pc4_q        <= '0;
        id_rd1_q        <= '0;
        id_rd2_q        <= '0;
        id_imm_q        <= '0;
        id_rs_q         <= '0;
        id_rt_q         <= '0;
        id_rd_q         <= '0;
        id_reg_dst_q    <= 1'b0;
        id_alu_src_q    <= 1'b0;
        id_mem_to_reg_q <= 1'b0;
        id_reg_write_q  <= 1'b0;
        id_mem_read_q   <= 1'b0;
        id_mem_write_q  <= 1'b0;
        id_branch_q     <= 1'b0;
        id_alu_op_q     <= 2'b00;
      end
    end else begin
      id_valid_q      <= ifid_valid_q;
      id_pc4_q        <= ifid_pc4_q;
      id_rd1_q        <= rd1_d;
      id_rd2_q        <= rd2_d;
      id_imm_q        <= sign_imm_d;
      id_rs_q         <= rs;
      id_rt_q         <= rt;
      id_rd_q         <= rd;
      id_reg_dst_q    <= reg_dst_d;
      id_alu_src_q    <= alu_src_d;
      id_mem_to_reg_q <= mem_to_reg_d;
      id_reg_write_q  <= reg_write_d;
      id_mem_read_q   <= mem_read_d;
      id_mem_write_q  <= mem_write_d;
      id_branch_q     <= branch_d;
      id_alu_op_q     <= alu_op_d;
    end
  end

  assign id_valid      = id_valid_q;
  assign id_pc4        = id_pc4_q;
  assign id_read_data1 = id_rd1_q;
  assign id_read_data2 = id_rd2_q;
  assign id_sign_imm   = id_imm_q;
  assign id_rs         = id_rs_q;
  assign id_rt         = id_rt_q;
  assign id_rd         = id_rd_q;
  assign id_reg_dst    = id_reg_dst_q;
  assign id_alu_src    = id_alu_src_q;
  assign id_mem_to_reg = id_mem_to_reg_q;
  assign id_reg_write  = id_reg_write_q;
  assign id_mem_read   = id_mem_read_q;
  assign id_mem_write  = id_mem_write_q;
  assign id_branch     = id_branch_q;
  assign id_alu_op     = id_alu_op_q;

endmodule
`default_nettype wire

// File: tb/tb_stage2_decode.sv
`default_nettype none
// ============================================================================
//  Module      : tb_stage2_decode
//  Description : Directed self-checking bench for stage2_decode.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_stage2_decode;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] if_pc4;
  logic [31:0] if_instruction;
  logic        flush;
  logic        wb_reg_write;
  logic [4:0]  wb_write_reg;
  logic [31:0] wb_write_data;
  logic        pc_enable;
  logic        id_valid;
  logic [31:0] id_pc4, id_read_data1, id_read_data2, id_sign_imm;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        id_reg_dst, id_alu_src, id_mem_to_reg, id_reg_write;
  logic        id_mem_read, id_mem_write, id_branch;
  logic [1:0]  id_alu_op;

  int n_assert = 0;
  int n_fail   = 0;

  stage2_decode #(.WIDTH(32)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .if_pc4         (if_pc4),
    .if_instruction (if_instruction),
    .flush          (flush),
    .wb_reg_write   (wb_reg_write),
    .wb_write_reg   (wb_write_reg),
    .wb_write_data  (wb_write_data),
    .pc_enable      (pc_enable),
    .id_valid       (id_valid),
    .id_pc4         (id_pc4),
    .id_read_data1  (id_read_data1),
    .id_read_data2  (id_read_data2),
    .id_sign_imm    (id_sign_imm),
    .id_rs          (id_rs),
    .id_rt          (id_rt),
    .id_rd          (id_rd),
    .id_reg_dst     (id_reg_dst),
    .id_alu_src     (id_alu_src),
    .id_mem_to_reg  (id_mem_to_reg),
    .id_reg_write   (id_reg_write),
    .id_mem_read    (id_mem_read),
    .id_mem_write   (id_mem_write),
    .id_branch      (id_branch),
    .id_alu_op      (id_alu_op)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  localparam logic [31:0] c_ADD_3_1_2   = 32'h0022_1820; // add $3,$1,$2
  localparam logic [31:0] c_LW_4_1      = 32'h8C24_0000; // lw  $4,0($1)
  localparam logic [31:0] c_ADD_5_4_2   = 32'h0082_2820; // add $5,$4,$2
  localparam logic [31:0] c_LW_0_1      = 32'h8C20_0000; // lw  $0,0($1)
  localparam logic [31:0] c_ADD_5_0_2   = 32'h0002_2820; // add $5,$0,$2
  localparam logic [31:0] c_BEQ_1_2     = 32'h1022_0010; // beq $1,$2,16
  localparam logic [31:0] c_ADD_8_6_2   = 32'h00C2_4020; // add $8,$6,$2
  localparam logic [31:0] c_ADD_9_0_6   = 32'h0006_4820; // add $9,$0,$6
  localparam logic [31:0] c_ADDI_7_1_M4 = 32'h2027_FFFC; // addi $7,$1,-4
  localparam logic [31:0] c_SW_2_1      = 32'hAC22_0008; // sw  $2,8($1)
  localparam logic [31:0] c_UNKNOWN     = 32'hFC00_0000; // opcode 0x3F

  initial begin
    rst_n          = 1'b0;
    flush          = 1'b0;
    wb_reg_write   = 1'b0;
    wb_write_reg   = 5'd0;
    wb_write_data  = 32'd0;
    if_pc4         = 32'd0;
    if_instruction = 32'd0;

    // Reset state
    #3;
    chk("rst_pc_enable", {31'd0, pc_enable}, 32'd1);
    chk("rst_id_valid", {31'd0, id_valid}, 32'd0);
    chk("rst_reg_write", {31'd0, id_reg_write}, 32'd0);
    chk("rst_pc4", id_pc4, 32'd0);
    tick();
    rst_n = 1'b1;

    // Preload $1=5, $2=7
    wb_reg_write = 1'b1; wb_write_reg = 5'd1; wb_write_data = 32'd5;
    tick();
    wb_write_reg = 5'd2; wb_write_data = 32'd7;
    tick();
    wb_reg_write = 1'b0;

    // R-type decode, two-edge latency
    if_instruction = c_ADD_3_1_2; if_pc4 = 32'h104;
    tick();
    if_instruction = 32'd0; if_pc4 = 32'h108;
    tick();
    chk("add_valid", {31'd0, id_valid}, 32'd1);
    chk("add_rd1", id_read_data1, 32'd5);
    chk("add_rd2", id_read_data2, 32'd7);
    chk("add_rd", {27'd0, id_rd}, 32'd3);
    chk("add_rs", {27'd0, id_rs}, 32'd1);
    chk("add_rt", {27'd0, id_rt}, 32'd2);
    chk("add_alu_op", {30'd0, id_alu_op}, 32'd2);
    chk("add_reg_dst", {31'd0, id_reg_dst}, 32'd1);
    chk("add_reg_write", {31'd0, id_reg_write}, 32'd1);
    chk("add_pc4", id_pc4, 32'h104);

    // Load-use stall
    if_instruction = c_LW_4_1;
    tick();
    if_instruction = c_ADD_5_4_2;
    tick();
    chk("lu_stall_pc_en", {31'd0, pc_enable}, 32'd0);
    chk("lu_lw_mem_read", {31'd0, id_mem_read}, 32'd1);
    chk("lu_lw_mem_to_reg", {31'd0, id_mem_to_reg}, 32'd1);
    chk("lu_lw_alu_src", {31'd0, id_alu_src}, 32'd1);
    tick();
    chk("lu_bubble_valid", {31'd0, id_valid}, 32'd0);
    chk("lu_bubble_mem_read", {31'd0, id_mem_read}, 32'd0);
    chk("lu_after_pc_en", {31'd0, pc_enable}, 32'd1);
    if_instruction = 32'd0;
    tick();
    chk("lu_add_valid", {31'd0, id_valid}, 32'd1);
    chk("lu_add_rs", {27'd0, id_rs}, 32'd4);
    chk("lu_add_rd", {27'd0, id_rd}, 32'd5);

    // Load to $0 must not stall
    if_instruction = c_LW_0_1;
    tick();
    if_instruction = c_ADD_5_0_2;
    tick();
    chk("nofalse_pc_en", {31'd0, pc_enable}, 32'd1);
    if_instruction = 32'd0;
    tick();
    chk("nofalse_valid", {31'd0, id_valid}, 32'd1);
    chk("nofalse_rd", {27'd0, id_rd}, 32'd5);

    // beq decode
    if_instruction = c_BEQ_1_2;
    tick();
    if_instruction = 32'd0;
    tick();
    chk("beq_branch", {31'd0, id_branch}, 32'd1);
    chk("beq_alu_op", {30'd0, id_alu_op}, 32'd1);
    chk("beq_reg_write", {31'd0, id_reg_write}, 32'd0);
    chk("beq_imm", id_sign_imm, 32'h10);

    // Flush with beq in IF/ID
    if_instruction = c_BEQ_1_2;
    tick();
    flush = 1'b1; if_instruction = 32'd0;
    tick();
    chk("flush_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_branch", {31'd0, id_branch}, 32'd0);
    chk("flush_alu_op", {30'd0, id_alu_op}, 32'd0);
    flush = 1'b0;
    tick();
    chk("flush_squashed_valid", {31'd0, id_valid}, 32'd0);
    chk("flush_squashed_rd1", id_read_data1, 32'd0);

    // Flush and stall in the same cycle
    if_instruction = c_LW_4_1;
    tick();
    if_instruction = c_ADD_5_4_2;
    tick();
    chk("fs_stall_pc_en", {31'd0, pc_enable}, 32'd0);
    flush = 1'b1;
    tick();
    chk("fs_valid", {31'd0, id_valid}, 32'd0);
    chk("fs_mem_read", {31'd0, id_mem_read}, 32'd0);
    chk("fs_pc_en", {31'd0, pc_enable}, 32'd1);
    flush = 1'b0; if_instruction = 32'd0;
    tick();
    chk("fs_after_valid", {31'd0, id_valid}, 32'd0);

    // Writeback bypass into a same-cycle read
    if_instruction = c_ADD_8_6_2;
    tick();
    wb_reg_write = 1'b1; wb_write_reg = 5'd6; wb_write_data = 32'hDEAD_BEEF;
    tick();
    chk("byp_rd1", id_read_data1, 32'hDEAD_BEEF);
    chk("byp_rd2", id_read_data2, 32'd7);

    // Write to $0 is ignored, including on the bypass path
    if_instruction = c_ADD_9_0_6; wb_write_reg = 5'd0; wb_write_data = 32'd9;
    tick();
    tick();
    chk("r0_rd1", id_read_data1, 32'd0);
    chk("r0_rd2", id_read_data2, 32'hDEAD_BEEF);
    wb_reg_write = 1'b0;

    // addi with negative immediate
    if_instruction = c_ADDI_7_1_M4;
    tick();
    if_instruction = 32'd0;
    tick();
    chk("addi_imm", id_sign_imm, 32'hFFFF_FFFC);
    chk("addi_alu_src", {31'd0, id_alu_src}, 32'd1);
    chk("addi_reg_dst", {31'd0, id_reg_dst}, 32'd0);
    chk("addi_reg_write", {31'd0, id_reg_write}, 32'd1);
    chk("addi_rd1", id_read_data1, 32'd5);

    // sw decode
    if_instruction = c_SW_2_1;
    tick();
    if_instruction = 32'd0;
    tick();
    chk("sw_mem_write", {31'd0, id_mem_write}, 32'd1);
    chk("sw_reg_write", {31'd0, id_reg_write}, 32'd0);
    chk("sw_rd2", id_read_data2, 32'd7);

    // Unknown opcode decodes as NOP but stays valid
    if_instruction = c_UNKNOWN;
    tick();
    if_instruction = 32'd0;
    tick();
    chk("unk_valid", {31'd0, id_valid}, 32'd1);
    chk("unk_reg_write", {31'd0, id_reg_write}, 32'd0);
    chk("unk_alu_src", {31'd0, id_alu_src}, 32'd0);

    // Reset in the middle of a stall
    if_instruction = c_LW_4_1;
    tick();
    if_instruction = c_ADD_5_4_2;
    tick();
    chk("rs_stall_pc_en", {31'd0, pc_enable}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rs_pc_en", {31'd0, pc_enable}, 32'd1);
    chk("rs_valid", {31'd0, id_valid}, 32'd0);
    chk("rs_mem_read", {31'd0, id_mem_read}, 32'd0);
    chk("rs_rd1", id_read_data1, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    if_instruction = c_ADD_3_1_2;
    tick();
    if_instruction = 32'd0;
    tick();
    chk("rs_regs_cleared", id_read_data1, 32'd0);
    chk("rs_restart_valid", {31'd0, id_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
